// File: rtl/fp_add_pkg.sv
// Shared definitions for the single-precision align/add stage.
// Holds the FSM state encoding, IEEE-754 field widths and the operand
// struct that overlays a 32-bit single-precision word.
package fp_add_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_W    = 24;   // hidden bit + fraction
  localparam int SUM_W     = 32;
  localparam int MAX_SHIFT = 24;   // beyond this the smaller mantissa is all zeros
  localparam int CNT_W     = 5;    // holds 0..MAX_SHIFT

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } operand_t;

endpackage

// File: rtl/fp_operand_swap.sv
// Combinational magnitude compare and swap.
// Orders two single-precision operands by {exp, frac}; on a tie operand a
// is taken as the larger. Produces the larger operand's sign and exponent,
// both 24-bit mantissas (hidden bit set for non-zero exponents) and the
// alignment shift count clamped to MAX_SHIFT.
//   a, b    : operands
//   l_sign  : sign of the larger-magnitude operand
//   l_exp   : exponent of the larger-magnitude operand
//   l_mant  : mantissa of the larger-magnitude operand
//   s_mant  : mantissa of the smaller-magnitude operand (unshifted)
//   shift   : min(l_exp - s_exp, MAX_SHIFT)
module fp_operand_swap
  import fp_add_pkg::*;
(
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              l_sign,
  output logic [EXP_W-1:0]  l_exp,
  output logic [MANT_W-1:0] l_mant,
  output logic [MANT_W-1:0] s_mant,
  output logic [CNT_W-1:0]  shift
);

  operand_t         op_a, op_b, op_l, op_s;
  logic [EXP_W-1:0] exp_diff;

  assign op_a = a;
  assign op_b = b;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    op_l = op_a;
    op_s = op_b;
    if ({op_b.exp, op_b.frac} > {op_a.exp, op_a.frac}) begin
      op_l = op_b;
      op_s = op_a;
    end
    // L >= S on {exp, frac}, so the exponent difference cannot go negative.
    exp_diff = op_l.exp - op_s.exp;
    shift    = (exp_diff > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT)
                                              : exp_diff[CNT_W-1:0];
    l_sign   = op_l.sign;
    l_exp    = op_l.exp;
    // Denormals (exp == 0) simply carry a zero hidden bit.
    l_mant   = {op_l.exp != '0, op_l.frac};
    s_mant   = {op_s.exp != '0, op_s.frac};
  end

endmodule

// File: rtl/fp_align_add.sv
// Operand-alignment and mantissa add/subtract stage of the single-precision
// adder, feeding the normalization stage.
// Accepts two operands over valid/ready, shifts the smaller mantissa right
// one bit per clock until aligned, then adds or subtracts the mantissas.
//   clk, rst    : clock, synchronous active-high reset
//   a, b        : operands (in_valid / in_ready handshake)
//   sum         : raw mantissa result, bit 24 carry, bit 23 hidden, 22:0 fraction
//   e1          : exponent of the larger-magnitude operand
//   flag        : 0 = effective add, 1 = effective subtract
//   sign        : result sign
//   out_valid / out_ready : result handshake
module fp_align_add
  import fp_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum,
  output logic [EXP_W-1:0]  e1,
  output logic              flag,
  output logic              sign,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [MANT_W-1:0] m_l, m_s;
  logic [EXP_W-1:0]  e_l;

  logic              sw_sign;
  logic [EXP_W-1:0]  sw_exp;
  logic [MANT_W-1:0] sw_l_mant, sw_s_mant;
  logic [CNT_W-1:0]  sw_shift;
  logic [MANT_W:0]   mant_res;

  fp_operand_swap u_swap (
    .a      (a),
    .b      (b),
    .l_sign (sw_sign),
    .l_exp  (sw_exp),
    .l_mant (sw_l_mant),
    .s_mant (sw_s_mant),
    .shift  (sw_shift)
  );

  // Subtraction never underflows because the larger magnitude is always m_l.
  always_comb begin
    mant_res = flag ? ({1'b0, m_l} - {1'b0, m_s})
                    : ({1'b0, m_l} + {1'b0, m_s});
  end

  // Both handshake outputs decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      m_l   <= '0;
      m_s   <= '0;
      e_l   <= '0;
      sum   <= '0;
      e1    <= '0;
      flag  <= 1'b0;
      sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_l   <= sw_l_mant;
            m_s   <= sw_s_mant;
            e_l   <= sw_exp;
            cnt   <= sw_shift;
            sign  <= sw_sign;
            flag  <= a[31] ^ b[31];
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (cnt != '0) begin
            // Bits shifted out are discarded: no guard/round/sticky.
            m_s <= m_s >> 1;
            cnt <= cnt - CNT_W'(1);
          end else begin
            sum   <= {{(SUM_W-MANT_W-1){1'b0}}, mant_res};
            e1    <= e_l;
            // A result whose low 24 bits are all zero is reported positive.
            if (mant_res[MANT_W-1:0] == '0) sign <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
